// File: rtl/ibex_pext_ov_csr.sv
// P-extension saturation (OV/vxsat) flag owner: collects sticky saturation from retiring
// ops and serves RDOV/CLROV/CSR accesses once every in-flight saturating op has drained.
module ibex_pext_ov_csr #(
    parameter int unsigned MaxOutstanding = 4,
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            issue_i,
    output logic            issue_ready_o,
    input  logic            ov_valid_i,
    input  logic            ov_set_i,
    input  logic            ov_kill_i,
    input  logic            flush_i,
    input  logic            rdov_req_i,
    input  logic            clrov_req_i,
    input  logic            csr_req_i,
    input  logic [1:0]      csr_op_i,
    input  logic [31:0]     csr_wdata_i,
    output logic            req_ready_o,
    output logic            rd_we_o,
    output logic [31:0]     rd_wdata_o,
    output logic            ov_o,
    output logic [CntW-1:0] outstanding_o
);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        RESPOND
    } state_t;

    localparam logic [1:0] CSR_READ  = 2'd0;
    localparam logic [1:0] CSR_WRITE = 2'd1;
    localparam logic [1:0] CSR_SET   = 2'd2;
    localparam logic [1:0] CSR_CLEAR = 2'd3;

    state_t          state_reg, state_next;
    logic [CntW-1:0] count_reg, count_next;
    logic            ov_reg, ov_next;

    logic any_req;
    logic count_full;
    logic do_retire;
    logic do_issue;
    logic unused_wdata;

    assign unused_wdata = ^csr_wdata_i[31:1];

    assign any_req    = csr_req_i | clrov_req_i | rdov_req_i;
    assign count_full = (count_reg == CntW'(MaxOutstanding));
    // A retire with nothing in flight is spurious and must not underflow the counter.
    assign do_retire  = ov_valid_i & (count_reg != '0);

    // A retire in the same cycle frees the slot, so a full tracker can still take an issue.
    assign issue_ready_o = (state_reg == IDLE) & (~count_full | do_retire);
    assign do_issue      = issue_i & issue_ready_o & ~flush_i;

    always_comb begin
        count_next = count_reg;
        if (flush_i) begin
            count_next = '0;
        end else if (do_issue && !do_retire) begin
            count_next = count_reg + 1'b1;
        end else if (!do_issue && do_retire) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_comb begin
        state_next  = state_reg;
        req_ready_o = 1'b0;
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    state_next = (count_next == '0) ? RESPOND : DRAIN;
                end
            end
            DRAIN: begin
                if (!any_req) begin
                    state_next = IDLE;
                end else if (count_next == '0) begin
                    state_next = RESPOND;
                end
            end
            RESPOND: begin
                req_ready_o = any_req & ~flush_i;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (flush_i) begin
            state_next = IDLE;
        end
    end

    // CSR wins over CLROV, which wins over RDOV; only CLROV skips the rd write.
    assign rd_we_o    = req_ready_o & (csr_req_i | ~clrov_req_i);
    assign rd_wdata_o = rd_we_o ? {31'b0, ov_reg} : 32'b0;

    always_comb begin
        ov_next = ov_reg;
        if (do_retire && ov_set_i && !ov_kill_i) begin
            ov_next = 1'b1;
        end
        if (req_ready_o) begin
            if (csr_req_i) begin
                case (csr_op_i)
                    CSR_READ:  ov_next = ov_reg;
                    CSR_WRITE: ov_next = csr_wdata_i[0];
                    CSR_SET:   ov_next = ov_reg | csr_wdata_i[0];
                    CSR_CLEAR: ov_next = ov_reg & ~csr_wdata_i[0];
                    default:   ov_next = ov_reg;
                endcase
            end else if (clrov_req_i) begin
                ov_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            count_reg <= '0;
            ov_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            ov_reg    <= ov_next;
        end
    end

    assign ov_o          = ov_reg;
    assign outstanding_o = count_reg;

endmodule

// File: tb/tb_ibex_pext_ov_csr.sv
// Directed bench for ibex_pext_ov_csr: a per-cycle reference model plus hand-computed
// spot checks of the key scenarios.
module tb_ibex_pext_ov_csr;
    localparam int MAXO = 4;
    localparam int CW   = $clog2(MAXO + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          issue = 1'b0, ov_valid = 1'b0, ov_set = 1'b0, ov_kill = 1'b0, flush = 1'b0;
    logic          rdov = 1'b0, clrov = 1'b0, csr = 1'b0;
    logic [1:0]    csr_op = 2'd0;
    logic [31:0]   csr_wdata = 32'd0;
    logic          issue_ready, req_ready, rd_we, ov;
    logic [31:0]   rd_wdata;
    logic [CW-1:0] outstanding;

    always #5 clk = ~clk;

    ibex_pext_ov_csr #(.MaxOutstanding(MAXO)) dut (
        .clk_i(clk), .rst_i(rst), .issue_i(issue), .issue_ready_o(issue_ready),
        .ov_valid_i(ov_valid), .ov_set_i(ov_set), .ov_kill_i(ov_kill), .flush_i(flush),
        .rdov_req_i(rdov), .clrov_req_i(clrov), .csr_req_i(csr), .csr_op_i(csr_op),
        .csr_wdata_i(csr_wdata), .req_ready_o(req_ready), .rd_we_o(rd_we),
        .rd_wdata_o(rd_wdata), .ov_o(ov), .outstanding_o(outstanding)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: in-flight count, flag, and where a pending request stands.
    int m_count = 0;
    bit m_ov = 0;
    bit m_waiting = 0;   // request seen, still waiting for in-flight ops to drain
    bit m_due = 0;       // drained: the request completes this cycle if still present
    bit m_live = 0;

    always @(negedge clk) begin
        bit any, retire, e_iready, e_rready, e_we, issue_ok, old_ov;
        bit [31:0] e_wdata;
        any      = csr | clrov | rdov;
        retire   = ov_valid && (m_count > 0);
        e_iready = !m_waiting && !m_due && ((m_count < MAXO) || retire);
        e_rready = m_due && any && !flush;
        e_we     = e_rready && (csr || !clrov);
        e_wdata  = e_we ? {31'b0, m_ov} : 32'b0;
        if (m_live) begin
            check("model_issue_ready", {31'b0, issue_ready}, {31'b0, e_iready});
            check("model_req_ready", {31'b0, req_ready}, {31'b0, e_rready});
            check("model_rd_we", {31'b0, rd_we}, {31'b0, e_we});
            check("model_rd_wdata", rd_wdata, e_wdata);
            check("model_ov", {31'b0, ov}, {31'b0, m_ov});
            check("model_outstanding", 32'(outstanding), 32'(m_count));
        end
        if (rst) begin
            m_count = 0; m_ov = 0; m_waiting = 0; m_due = 0; m_live = 1;
        end else begin
            old_ov   = m_ov;
            issue_ok = issue && e_iready && !flush;
            if (retire && ov_set && !ov_kill) m_ov = 1;
            if (e_rready) begin
                if (csr) begin
                    case (csr_op)
                        2'd1: m_ov = csr_wdata[0];
                        2'd2: m_ov = old_ov | csr_wdata[0];
                        2'd3: m_ov = old_ov & ~csr_wdata[0];
                        default: m_ov = old_ov;
                    endcase
                end else if (clrov) begin
                    m_ov = 0;
                end
            end
            m_count = flush ? 0 : m_count + int'(issue_ok) - int'(retire);
            if (flush || m_due) begin
                m_waiting = 0; m_due = 0;
            end else if (any) begin
                m_due     = (m_count == 0);
                m_waiting = (m_count != 0);
            end else begin
                m_waiting = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind: 0=RDOV 1=CLROV 2=CSR 3=CSR+CLROV together
    task automatic do_req(input int kind, input logic [1:0] op, input logic [31:0] wd,
                          output logic [31:0] rdata, output logic we, output int lat);
        bit done;
        done = 0; rdata = 0; we = 0; lat = 0;
        rdov  = (kind == 0);
        clrov = (kind == 1) || (kind == 3);
        csr   = (kind >= 2);
        csr_op = op; csr_wdata = wd;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_ready) begin
                rdata = rd_wdata; we = rd_we; done = 1;
                break;
            end
            lat++;
            tick();
        end
        check("req_handshake_timeout", {31'b0, done}, 32'd1);
        tick();
        rdov = 0; clrov = 0; csr = 0; csr_op = 0; csr_wdata = 0;
    endtask

    logic [31:0] rdata;
    logic        we;
    int          lat;

    initial begin
        tick(); tick();
        rst = 0;
        @(negedge clk);
        check("reset_issue_ready", {31'b0, issue_ready}, 32'd1);
        check("reset_outstanding", 32'(outstanding), 32'd0);
        tick();

        // RDOV with nothing in flight
        do_req(0, 2'd0, 32'd0, rdata, we, lat);
        $display("RDOV idle: rdata=%0h we=%0b lat=%0d", rdata, we, lat);
        check("rdov_idle_lat", 32'(lat), 32'd1);
        check("rdov_idle_we", {31'b0, we}, 32'd1);
        check("rdov_idle_rdata", rdata, 32'd0);

        // Three ops, RDOV drains behind them; only the last one saturates
        issue = 1; tick(); tick(); tick(); issue = 0;
        tick();
        rdov = 1; tick();
        ov_valid = 1; tick(); ov_valid = 0;
        @(negedge clk);
        check("drain_issue_ready", {31'b0, issue_ready}, 32'd0);
        check("drain_outstanding", 32'(outstanding), 32'd2);
        tick();
        ov_valid = 1; tick(); ov_valid = 0; tick();
        ov_valid = 1; ov_set = 1; tick(); ov_valid = 0; ov_set = 0;
        @(negedge clk);
        $display("RDOV drained: ready=%0b rdata=%0h", req_ready, rd_wdata);
        check("drain_respond_ready", {31'b0, req_ready}, 32'd1);
        check("drain_respond_rdata", rd_wdata, 32'd1);
        check("drain_respond_issue_ready", {31'b0, issue_ready}, 32'd0);
        tick(); rdov = 0; tick();

        // CLROV clears the flag without writing rd
        do_req(1, 2'd0, 32'd0, rdata, we, lat);
        $display("CLROV: rdata=%0h we=%0b", rdata, we);
        check("clrov_we", {31'b0, we}, 32'd0);
        check("clrov_rdata", rdata, 32'd0);
        @(negedge clk);
        check("clrov_ov", {31'b0, ov}, 32'd0);
        tick();

        // A killed saturating retire leaves the flag alone
        issue = 1; tick(); issue = 0;
        ov_valid = 1; ov_set = 1; ov_kill = 1; tick();
        ov_valid = 0; ov_set = 0; ov_kill = 0;
        @(negedge clk);
        $display("killed retire: ov=%0b outstanding=%0d", ov, outstanding);
        check("kill_ov", {31'b0, ov}, 32'd0);
        check("kill_outstanding", 32'(outstanding), 32'd0);
        tick();

        // CSR write/set/clear/read sequence
        do_req(2, 2'd1, 32'h1, rdata, we, lat);
        $display("CSR WRITE 1: rdata=%0h", rdata);
        check("csr_write_rdata", rdata, 32'd0);
        check("csr_write_we", {31'b0, we}, 32'd1);
        @(negedge clk); check("csr_write_ov", {31'b0, ov}, 32'd1); tick();
        do_req(2, 2'd2, 32'h0, rdata, we, lat);
        $display("CSR SET 0: rdata=%0h", rdata);
        check("csr_set_rdata", rdata, 32'd1);
        @(negedge clk); check("csr_set_ov", {31'b0, ov}, 32'd1); tick();
        do_req(2, 2'd3, 32'h1, rdata, we, lat);
        $display("CSR CLEAR 1: rdata=%0h", rdata);
        check("csr_clear_rdata", rdata, 32'd1);
        @(negedge clk); check("csr_clear_ov", {31'b0, ov}, 32'd0); tick();
        do_req(2, 2'd0, 32'h0, rdata, we, lat);
        $display("CSR READ: rdata=%0h we=%0b", rdata, we);
        check("csr_read_rdata", rdata, 32'd0);
        check("csr_read_we", {31'b0, we}, 32'd1);

        // Fill the tracker; a fifth issue is dropped
        issue = 1; repeat (5) tick(); issue = 0;
        @(negedge clk);
        $display("full: outstanding=%0d issue_ready=%0b", outstanding, issue_ready);
        check("full_outstanding", 32'(outstanding), 32'd4);
        check("full_issue_ready", {31'b0, issue_ready}, 32'd0);
        tick();
        issue = 1; ov_valid = 1; tick(); issue = 0; ov_valid = 0;
        @(negedge clk);
        check("full_issue_retire_outstanding", 32'(outstanding), 32'd4);
        tick();

        // Flush while draining with two in flight
        ov_valid = 1; tick(); tick(); ov_valid = 0;
        rdov = 1; tick(); tick();
        flush = 1;
        @(negedge clk);
        check("flush_pre_outstanding", 32'(outstanding), 32'd2);
        tick();
        flush = 0; rdov = 0;
        @(negedge clk);
        $display("flush: outstanding=%0d ready=%0b", outstanding, req_ready);
        check("flush_outstanding", 32'(outstanding), 32'd0);
        check("flush_req_ready", {31'b0, req_ready}, 32'd0);
        tick();
        do_req(0, 2'd0, 32'd0, rdata, we, lat);
        check("flush_rerdov_lat", 32'(lat), 32'd1);

        // CSR beats CLROV when both are presented
        do_req(2, 2'd1, 32'h1, rdata, we, lat);
        do_req(3, 2'd0, 32'h0, rdata, we, lat);
        $display("CSR+CLROV: rdata=%0h we=%0b", rdata, we);
        check("prio_we", {31'b0, we}, 32'd1);
        check("prio_rdata", rdata, 32'd1);
        @(negedge clk); check("prio_ov", {31'b0, ov}, 32'd1); tick();

        // Reset in the middle of a drain
        issue = 1; tick(); tick(); issue = 0;
        rdov = 1; tick();
        rst = 1; tick(); rst = 0; rdov = 0;
        @(negedge clk);
        $display("reset mid-drain: ready=%0b we=%0b ov=%0b outstanding=%0d issue_ready=%0b",
                 req_ready, rd_we, ov, outstanding, issue_ready);
        check("rst_req_ready", {31'b0, req_ready}, 32'd0);
        check("rst_rd_we", {31'b0, rd_we}, 32'd0);
        check("rst_rd_wdata", rd_wdata, 32'd0);
        check("rst_ov", {31'b0, ov}, 32'd0);
        check("rst_outstanding", 32'(outstanding), 32'd0);
        check("rst_issue_ready", {31'b0, issue_ready}, 32'd1);
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "timeout");
    end
endmodule
